icache: RTL and testbench
=========================

# icache

Direct-mapped, read-only instruction cache that answers the fetch stage's PC each cycle with a 32-bit instruction word. It sits between the fetch stage and instruction memory: hits return data combinationally in the same cycle, while misses raise a stall and run a line refill from memory through a request/ready handshake. Its stall output feeds the core stall network that freezes fetch.

## Interface
- `LINES`, 4, number of cache lines; power of two, ≥2
- `LINE_W`, 128, line width in bits; four 32-bit words
- `ADDR_W`, 32, address width
- `clk_i`  in  1  clock; all state updates on rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `pc_i`  in  ADDR_W  fetch address; bits [1:0] ignored
- `flush_i`  in  1  invalidate all lines (fence.i / exception entry)
- `instr_o`  out  32  instruction word at `pc_i`; valid when `stall_o`=0
- `stall_o`  out  1  miss or refill in progress; fetch must hold PC
- `mem_req_o`  out  1  refill request, level-held until accepted
- `mem_addr_o`  out  ADDR_W  line-aligned refill address (low 4 bits zero)
- `mem_ready_i`  in  1  memory returns line; one-cycle pulse
- `mem_data_i`  in  LINE_W  refill line, word 0 in bits [31:0]

## Operation
- Address split: offset [3:0], with word select [3:2]; index [3+log2(LINES):4]; tag is the remaining upper bits.
- Per line: valid bit, tag, and `LINE_W` data bits. Tag and data are not reset; valid bits are.
- Hit means `valid[index] && tag[index]==pc_i.tag`. `instr_o` is the selected word of `data[index]`.
- On a miss, `instr_o` drives the selected word of whatever the indexed line holds; the value is don't-care because `stall_o` is asserted.
- FSM states:
  - IDLE: `stall_o` = !hit. On a miss, latch the line address of `pc_i` into `mem_addr_o` and move to REQ.
  - REQ: `mem_req_o`=1, `stall_o`=1. When `mem_ready_i`=1, write `mem_data_i` and the latched tag into the latched index, set valid, and move to FILL.
  - FILL: `mem_req_o`=0. Lookup is re-run on the current `pc_i`, so `stall_o` = !hit. Always move to IDLE; a miss here starts a new refill from IDLE on the next cycle.
- If `pc_i` changes during REQ (exception or iret redirect), the outstanding refill still completes for the latched address. The new PC is looked up in FILL.
- `flush_i`:
  - In IDLE or FILL, clear all valid bits at the clock edge. Same-cycle lookup still uses the pre-flush valid bits.
  - In REQ, clear all valid bits and mark the pending fill stale. The line is written when the data arrives, but its valid bit is not set.
  - `flush_i` together with `mem_ready_i` counts as stale: the line is not validated.
- Reset state: state=IDLE, all valid bits=0, `mem_req_o`=0, `mem_addr_o`=0, stale flag=0.
- Reset during REQ abandons the refill. A `mem_ready_i` pulse after reset is ignored.
- `mem_ready_i` outside REQ is ignored.

## Timing
- Hit latency: 0 cycles. `instr_o` and `stall_o`=0 are combinational from `pc_i`.
- Miss: `stall_o` goes high in the same cycle as the missing PC. `mem_req_o` rises on the next edge.
- Miss penalty = 2 + N cycles, where N is the number of cycles `mem_req_o` is high before `mem_ready_i`: 1 IDLE-miss cycle + N REQ cycles + 1 FILL cycle. `instr_o` is valid in FILL.
- `mem_req_o` and `mem_addr_o` are stable throughout REQ.
- Outputs after reset release: `stall_o`=1 for any PC, since all lines are invalid.

## Configuration
- `ICACHE_PERF_CNT_EN`: when defined, adds the following outputs. When undefined, the ports and counters are absent and behaviour is otherwise identical.
  - `hit_cnt_o`  out  32: counts IDLE/FILL cycles with a hit.
  - `miss_cnt_o`  out  32: counts IDLE-to-REQ transitions.
  - Both counters saturate at 0xFFFFFFFF, reset to 0, and are cleared by `rst_i` only (not by `flush_i`).

## Test plan
- Cold miss: reset, `pc_i`=0x1000, memory returns 0x44444444_33333333_22222222_11111111 after 3 REQ cycles -> `mem_addr_o`=0x1000, `stall_o` high for 4 cycles, then `instr_o`=0x11111111 with `stall_o`=0.
- Sequential hits: after the fill, `pc_i`=0x1004, 0x1008, 0x100C -> `instr_o`=0x22222222, 0x33333333, 0x44444444, `stall_o`=0, no `mem_req_o`.
- Conflict eviction (LINES=4): fill 0x1000, then `pc_i`=0x1040 (same index 0) misses and refills -> returning to 0x1000 misses again with `mem_addr_o`=0x1000.
- Redirect mid-refill: miss on 0x1000, switch `pc_i` to 0x2000 during REQ -> line 0x1000 is filled and valid; FILL sees a miss and a new refill issues `mem_addr_o`=0x2000.
- Flush during REQ: `flush_i` pulsed while refilling 0x1000 -> after `mem_ready_i`, FILL reports a miss on 0x1000 and a second refill issues.
- Reset mid-refill: `rst_i` during REQ, then a late `mem_ready_i` -> `mem_req_o`=0, state IDLE, no line valid; with `ICACHE_PERF_CNT_EN`, counters read 0.

Source files
------------

// File: rtl/icache.sv
// icache -- direct-mapped, read-only instruction cache.
//
// Hits are answered combinationally in the same cycle as pc_i. A miss raises
// stall_o and runs a single-line refill through a req/ready handshake. The
// refill is tied to the address latched on the miss, so a redirect of pc_i
// during the refill does not cancel it. The new PC is looked up again in
// FILL.
//
// Parameters:
//   LINES   number of lines (power of two, >= 2)
//   LINE_W  line width in bits (four 32-bit words)
//   ADDR_W  address width
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   pc_i         fetch address (bits [1:0] ignored)
//   flush_i      invalidate all lines
//   instr_o      instruction word at pc_i, valid when stall_o = 0
//   stall_o      miss or refill in progress
//   mem_req_o    refill request, held until mem_ready_i
//   mem_addr_o   line-aligned refill address
//   mem_ready_i  one-cycle pulse carrying the refill line
//   mem_data_i   refill line, word 0 in bits [31:0]
//
// Optional feature (macro ICACHE_PERF_CNT_EN):
//   hit_cnt_o    saturating count of IDLE/FILL cycles that hit
//   miss_cnt_o   saturating count of IDLE-to-REQ transitions
module icache #(
  parameter int LINES  = 4,
  parameter int LINE_W = 128,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush_i,
  output logic [31:0]       instr_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ready_i,
  input  logic [LINE_W-1:0] mem_data_i
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 4 - IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              stale_reg, stale_next;
  logic [LINES-1:0]  valid_reg;

  // Tag and data storage are not reset; only the valid bits are.
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINE_W-1:0] data_mem [LINES];

  logic [IDX_W-1:0]  pc_idx;
  logic [TAG_W-1:0]  pc_tag;
  logic [1:0]        pc_word;
  logic [LINE_W-1:0] line_rd;
  logic              hit;

  logic              fill_we;
  logic              fill_valid;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;

  // The byte offset within a word never affects the lookup.
  logic              unused_pc_bits;
  assign unused_pc_bits = ^pc_i[1:0];

  assign pc_idx  = pc_i[IDX_W+3:4];
  assign pc_tag  = pc_i[ADDR_W-1:IDX_W+4];
  assign pc_word = pc_i[3:2];
  assign line_rd = data_mem[pc_idx];
  assign hit     = valid_reg[pc_idx] && (tag_mem[pc_idx] == pc_tag);
  assign instr_o = line_rd[{pc_word, 5'b00000} +: 32];

  assign fill_idx   = addr_reg[IDX_W+3:4];
  assign fill_tag   = addr_reg[ADDR_W-1:IDX_W+4];
  // A flush seen at any point of the refill, including the data cycle,
  // leaves the refilled line invalid.
  assign fill_valid = !stale_reg && !flush_i;
  assign mem_addr_o = addr_reg;

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    stale_next = stale_reg;
    stall_o    = 1'b1;
    mem_req_o  = 1'b0;
    fill_we    = 1'b0;
    case (state_reg)
      IDLE: begin
        stall_o = !hit;
        if (!hit) begin
          addr_next  = {pc_i[ADDR_W-1:4], 4'b0000};
          state_next = REQ;
        end
      end
      REQ: begin
        mem_req_o = 1'b1;
        if (flush_i) begin
          stale_next = 1'b1;
        end
        if (mem_ready_i) begin
          fill_we    = !rst_i;
          stale_next = 1'b0;
          state_next = FILL;
        end
      end
      FILL: begin
        stall_o    = !hit;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      stale_reg <= 1'b0;
      valid_reg <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      stale_reg <= stale_next;
      if (flush_i) begin
        valid_reg <= '0;
      end
      // Placed after the flush clear so the filled line's bit is decided
      // only by fill_valid, which already accounts for flush_i.
      if (fill_we) begin
        valid_reg[fill_idx] <= fill_valid;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_we) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem_data_i;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_reg;
  logic [31:0] miss_cnt_reg;
  logic        hit_evt;
  logic        miss_evt;

  assign hit_evt  = ((state_reg == IDLE) || (state_reg == FILL)) && hit;
  assign miss_evt = (state_reg == IDLE) && !hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      if (hit_evt && (hit_cnt_reg != 32'hFFFF_FFFF)) begin
        hit_cnt_reg <= hit_cnt_reg + 32'd1;
      end
      if (miss_evt && (miss_cnt_reg != 32'hFFFF_FFFF)) begin
        miss_cnt_reg <= miss_cnt_reg + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_reg;
  assign miss_cnt_o = miss_cnt_reg;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache (LINES=4). Expected instruction words are
// pushed to a scoreboard queue when a fetch is issued and popped when the
// cache delivers the word. A small memory model supplies refill lines.
module tb_icache;

  logic         clk_i;
  logic         rst_i;
  logic [31:0]  pc_i;
  logic         flush_i;
  logic [31:0]  instr_o;
  logic         stall_o;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_ready_i;
  logic [127:0] mem_data_i;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q [$];

  icache #(.LINES(4), .LINE_W(128), .ADDR_W(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .pc_i        (pc_i),
    .flush_i     (flush_i),
    .instr_o     (instr_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ready_i (mem_ready_i),
    .mem_data_i  (mem_data_i)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Memory model: line 0x1000 holds the fixed test pattern, every other
  // word is its own address XOR a constant.
  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    logic [31:0] w;
    if ((pc & 32'hFFFF_FFF0) == 32'h0000_1000) begin
      case (pc[3:2])
        2'd0:    w = 32'h1111_1111;
        2'd1:    w = 32'h2222_2222;
        2'd2:    w = 32'h3333_3333;
        default: w = 32'h4444_4444;
      endcase
    end else begin
      w = (pc & 32'hFFFF_FFFC) ^ 32'hC0DE_0000;
    end
    return w;
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) begin
      l[32*k +: 32] = exp_word(a + 32'(4 * k));
    end
    return l;
  endfunction

  // Drives one fetch to completion, serving refills with the given REQ
  // delay. Optionally redirects pc_i or pulses flush_i on the first REQ
  // cycle of the first refill. Returns what was observed; ends one cycle
  // after delivery so the cache is back in IDLE.
  task automatic run_fetch(input logic [31:0] pc, input int delay,
                           input bit do_redir, input logic [31:0] redir_pc,
                           input bit do_flush,
                           output logic [31:0] instr, output int stalls,
                           output logic [31:0] addr_seen, output int reqs,
                           output bit unstable, output bit timeout);
    bit prev_req = 1'b0;
    bit redir_done = 1'b0;
    bit flush_done = 1'b0;
    int rc = 0;
    instr = '0; stalls = 0; addr_seen = '0; reqs = 0;
    unstable = 1'b0; timeout = 1'b1;
    pc_i = pc;
    #1;
    for (int cyc = 0; cyc < 64; cyc++) begin
      if (!stall_o) begin
        instr = instr_o;
        timeout = 1'b0;
        break;
      end
      stalls++;
      if (mem_req_o) begin
        if (!prev_req) begin
          reqs++;
          rc = 0;
          addr_seen = mem_addr_o;
        end else if (mem_addr_o !== addr_seen) begin
          unstable = 1'b1;
        end
        rc++;
        if (rc == 1 && do_redir && !redir_done) begin
          pc_i = redir_pc;
          redir_done = 1'b1;
        end
        if (rc == 1 && do_flush && !flush_done) begin
          flush_i = 1'b1;
          flush_done = 1'b1;
        end
        if (rc == delay) begin
          mem_ready_i = 1'b1;
          mem_data_i  = mem_line(mem_addr_o);
        end
      end
      prev_req = mem_req_o;
      @(negedge clk_i);
      mem_ready_i = 1'b0;
      flush_i = 1'b0;
      #1;
    end
    @(negedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; pc_i = 32'h0000_1000; flush_i = 1'b0;
    mem_ready_i = 1'b0; mem_data_i = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    n_cmp++;
    if (stall_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_stall: got %b want 1", stall_o);
    end
    n_cmp++;
    if (mem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_req: got %b want 0", mem_req_o);
    end
    n_cmp++;
    if (mem_addr_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_addr: got %h want 0", mem_addr_o);
    end
    $display("reset: stall=%b req=%b addr=%h", stall_o, mem_req_o, mem_addr_o);
    // Re-sync so the next fetch starts at a cycle boundary in IDLE.
    rst_i = 1'b1; @(negedge clk_i); rst_i = 1'b0; #1;
  endtask

  task automatic test_cold_miss();
    logic [31:0] instr, addr, exp;
    int stalls, reqs;
    bit unst, to;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] miss0 = miss_cnt_o;
`endif
    exp_q.push_back(exp_word(32'h1000));
    run_fetch(32'h1000, 3, 0, 0, 0, instr, stalls, addr, reqs, unst, to);
    exp = exp_q.pop_front();
    $display("cold_miss: instr=%h stalls=%0d addr=%h reqs=%0d", instr, stalls, addr, reqs);
    n_cmp++;
    if (to || instr !== exp) begin
      n_fail++; $display("FAIL cold_instr: got %h want %h (timeout=%b)", instr, exp, to);
    end
    n_cmp++;
    if (stalls != 4) begin n_fail++; $display("FAIL cold_stalls: got %0d want 4", stalls); end
    n_cmp++;
    if (addr !== 32'h1000) begin n_fail++; $display("FAIL cold_addr: got %h want 00001000", addr); end
    n_cmp++;
    if (unst) begin n_fail++; $display("FAIL cold_addr_stable: got unstable want stable"); end
`ifdef ICACHE_PERF_CNT_EN
    n_cmp++;
    if (miss_cnt_o !== miss0 + 32'd1) begin
      n_fail++; $display("FAIL miss_cnt: got %0d want %0d", miss_cnt_o, miss0 + 1);
    end
`endif
  endtask

  task automatic test_seq_hits();
    logic [31:0] instr, addr, exp, pc;
    int stalls, reqs;
    bit unst, to;
    for (int i = 1; i < 4; i++) begin
      pc = 32'h1000 + 32'(4 * i);
      exp_q.push_back(exp_word(pc));
      run_fetch(pc, 1, 0, 0, 0, instr, stalls, addr, reqs, unst, to);
      exp = exp_q.pop_front();
      $display("seq_hit: pc=%h instr=%h stalls=%0d reqs=%0d", pc, instr, stalls, reqs);
      n_cmp++;
      if (to || instr !== exp || stalls != 0 || reqs != 0) begin
        n_fail++;
        $display("FAIL seq_hit_%0d: got instr=%h stalls=%0d reqs=%0d want %h/0/0",
                 i, instr, stalls, reqs, exp);
      end
    end
  endtask

  task automatic test_conflict();
    logic [31:0] instr, addr, exp;
    int stalls, reqs;
    bit unst, to;
    exp_q.push_back(exp_word(32'h1040));
    run_fetch(32'h1040, 2, 0, 0, 0, instr, stalls, addr, reqs, unst, to);
    exp = exp_q.pop_front();
    $display("conflict_fill: instr=%h addr=%h reqs=%0d", instr, addr, reqs);
    n_cmp++;
    if (to || instr !== exp || reqs != 1 || addr !== 32'h1040) begin
      n_fail++; $display("FAIL conflict_fill: got %h addr=%h reqs=%0d want %h addr=00001040 reqs=1",
                         instr, addr, reqs, exp);
    end
    exp_q.push_back(exp_word(32'h1000));
    run_fetch(32'h1000, 1, 0, 0, 0, instr, stalls, addr, reqs, unst, to);
    exp = exp_q.pop_front();
    $display("conflict_return: instr=%h addr=%h reqs=%0d stalls=%0d", instr, addr, reqs, stalls);
    n_cmp++;
    if (to || instr !== exp || reqs != 1 || addr !== 32'h1000 || stalls != 2) begin
      n_fail++; $display("FAIL conflict_return: got %h addr=%h reqs=%0d stalls=%0d want %h 00001000 1 2",
                         instr, addr, reqs, stalls, exp);
    end
  endtask

  task automatic test_flush_idle();
    logic [31:0] instr, addr, exp;
    int stalls, reqs;
    bit unst, to;
    pc_i = 32'h1008;
    flush_i = 1'b1;
    #1;
    // Same-cycle lookup still sees the pre-flush valid bits.
    n_cmp++;
    if (stall_o !== 1'b0 || instr_o !== 32'h3333_3333) begin
      n_fail++; $display("FAIL flush_same_cycle: got stall=%b instr=%h want 0 33333333", stall_o, instr_o);
    end
    @(negedge clk_i);
    flush_i = 1'b0;
    #1;
    n_cmp++;
    if (stall_o !== 1'b1) begin
      n_fail++; $display("FAIL flush_after: got stall=%b want 1", stall_o);
    end
    $display("flush_idle: stall after flush=%b", stall_o);
    exp_q.push_back(exp_word(32'h1008));
    run_fetch(32'h1008, 1, 0, 0, 0, instr, stalls, addr, reqs, unst, to);
    exp = exp_q.pop_front();
    n_cmp++;
    if (to || instr !== exp || reqs != 1) begin
      n_fail++; $display("FAIL flush_refill: got %h reqs=%0d want %h reqs=1", instr, reqs, exp);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] instr, addr, exp;
    int stalls, reqs;
    bit unst, to;
    // 0x1000 is valid; evict it so the redirect scenario starts with a miss.
    exp_q.push_back(exp_word(32'h1040));
    run_fetch(32'h1040, 1, 0, 0, 0, instr, stalls, addr, reqs, unst, to);
    void'(exp_q.pop_front());
    exp_q.push_back(exp_word(32'h2000));
    run_fetch(32'h1000, 2, 1, 32'h2000, 0, instr, stalls, addr, reqs, unst, to);
    exp = exp_q.pop_front();
    $display("redirect: instr=%h addr=%h reqs=%0d stalls=%0d", instr, addr, reqs, stalls);
    n_cmp++;
    if (to || instr !== exp || reqs != 2 || addr !== 32'h2000 || stalls != 7 || unst) begin
      n_fail++; $display("FAIL redirect: got %h addr=%h reqs=%0d stalls=%0d want %h 00002000 2 7",
                         instr, addr, reqs, stalls, exp);
    end
    // Redirect to a different index so the completed 0x1000 line survives.
    exp_q.push_back(exp_word(32'h2010));
    run_fetch(32'h1000, 1, 1, 32'h2010, 0, instr, stalls, addr, reqs, unst, to);
    void'(exp_q.pop_front());
    exp_q.push_back(exp_word(32'h1004));
    run_fetch(32'h1004, 1, 0, 0, 0, instr, stalls, addr, reqs, unst, to);
    exp = exp_q.pop_front();
    $display("redirect_keep: instr=%h stalls=%0d reqs=%0d", instr, stalls, reqs);
    n_cmp++;
    if (to || instr !== exp || stalls != 0 || reqs != 0) begin
      n_fail++; $display("FAIL redirect_line_valid: got %h stalls=%0d want %h stalls=0", instr, stalls, exp);
    end
  endtask

  task automatic test_flush_req();
    logic [31:0] instr, addr, exp;
    int stalls, reqs;
    bit unst, to;
    exp_q.push_back(exp_word(32'h1040));
    run_fetch(32'h1040, 1, 0, 0, 0, instr, stalls, addr, reqs, unst, to);
    void'(exp_q.pop_front());
    exp_q.push_back(exp_word(32'h100C));
    run_fetch(32'h100C, 3, 0, 0, 1, instr, stalls, addr, reqs, unst, to);
    exp = exp_q.pop_front();
    $display("flush_req: instr=%h reqs=%0d stalls=%0d addr=%h", instr, reqs, stalls, addr);
    n_cmp++;
    if (to || instr !== exp || reqs != 2 || stalls != 9 || addr !== 32'h1000) begin
      n_fail++; $display("FAIL flush_req: got %h reqs=%0d stalls=%0d addr=%h want %h 2 9 00001000",
                         instr, reqs, stalls, addr, exp);
    end
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] instr, addr, exp;
    int stalls, reqs;
    bit unst, to;
    pc_i = 32'h3000;
    @(negedge clk_i); #1;
    n_cmp++;
    if (mem_req_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_req_before: got %b want 1", mem_req_o);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    mem_ready_i = 1'b1;
    mem_data_i = {4{32'hDEAD_BEEF}};
    #1;
    n_cmp++;
    if (mem_req_o !== 1'b0 || stall_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_idle: got req=%b stall=%b want 0 1", mem_req_o, stall_o);
    end
`ifdef ICACHE_PERF_CNT_EN
    n_cmp++;
    if (hit_cnt_o !== 32'h0 || miss_cnt_o !== 32'h0) begin
      n_fail++; $display("FAIL rst_counters: got %0d/%0d want 0/0", hit_cnt_o, miss_cnt_o);
    end
`endif
    @(negedge clk_i);
    mem_ready_i = 1'b0;
    #1;
    // Late ready was ignored in IDLE; the miss on 0x3000 now requests anew.
    n_cmp++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h3000) begin
      n_fail++; $display("FAIL rst_mid_rerequest: got req=%b addr=%h want 1 00003000", mem_req_o, mem_addr_o);
    end
    exp_q.push_back(exp_word(32'h3004));
    run_fetch(32'h3004, 1, 0, 0, 0, instr, stalls, addr, reqs, unst, to);
    exp = exp_q.pop_front();
    n_cmp++;
    if (to || instr !== exp) begin
      n_fail++; $display("FAIL rst_mid_fill: got %h want %h", instr, exp);
    end
    // 0x1000 was valid before reset and must miss now.
    exp_q.push_back(exp_word(32'h1000));
    run_fetch(32'h1000, 1, 0, 0, 0, instr, stalls, addr, reqs, unst, to);
    exp = exp_q.pop_front();
    $display("reset_mid_refill: 0x1000 reqs=%0d instr=%h", reqs, instr);
    n_cmp++;
    if (to || instr !== exp || reqs != 1) begin
      n_fail++; $display("FAIL rst_mid_invalid: got %h reqs=%0d want %h reqs=1", instr, reqs, exp);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_seq_hits();
    test_conflict();
    test_flush_idle();
    test_redirect();
    test_flush_req();
    test_reset_mid_refill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
